// File: rtl/disparity_wta_scheduler.sv
// -----------------------------------------------------------------------------
// disparity_wta_scheduler
//   Shares one squared-difference matcher across NUM_DISP candidate disparities
//   for each left pixel. A pixel set (left pixel plus NUM_DISP right candidates)
//   is captured, the candidates are issued to the matcher one per cycle, and the
//   returned SSD values are reduced to a winner-take-all minimum. The winning
//   disparity and its SSD are presented downstream with valid/ready.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-low reset
//   valid_in / ready_out      pixel-set handshake (left_pixel_in, right_pixels_in)
//   dp_left_out, dp_right_out operands to the matcher, qualified by dp_valid_out
//   dp_ssd_in, dp_valid_in    result returned by the matcher
//   disparity_out, min_ssd_out, err_out
//                             winner, its SSD, and timeout-abort flag,
//                             qualified by valid_out / ready_in
// -----------------------------------------------------------------------------
module disparity_wta_scheduler #(
    parameter int NUM_DISP  = 9,
    parameter int PIX_W     = 4,
    parameter int SSD_W     = 9,
    parameter int MATCH_LAT = 2,
    parameter int TIMEOUT   = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [PIX_W-1:0]          left_pixel_in,
    input  logic [NUM_DISP*PIX_W-1:0] right_pixels_in,
    output logic [PIX_W-1:0]          dp_left_out,
    output logic [PIX_W-1:0]          dp_right_out,
    output logic                      dp_valid_out,
    input  logic [SSD_W-1:0]          dp_ssd_in,
    input  logic                      dp_valid_in,
    output logic [$clog2(NUM_DISP)-1:0] disparity_out,
    output logic [SSD_W-1:0]          min_ssd_out,
    output logic                      err_out,
    output logic                      valid_out,
    input  logic                      ready_in
);

    localparam int DISP_W = $clog2(NUM_DISP);
    localparam int CNT_W  = $clog2(NUM_DISP + 1);
    // Idle counter carries headroom for the matcher latency on top of TIMEOUT.
    localparam int IDLE_W = $clog2(TIMEOUT + MATCH_LAT + 1);

    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_DISP - 1);
    localparam logic [CNT_W-1:0]  ALL_CNT  = CNT_W'(NUM_DISP);
    localparam logic [IDLE_W-1:0] TO_LAST  = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PIX_W-1:0]    left_q, left_d;
    logic [PIX_W-1:0]    right_q [NUM_DISP];
    logic [PIX_W-1:0]    right_d [NUM_DISP];
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]    rcv_cnt_q, rcv_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [SSD_W-1:0]    best_ssd_q, best_ssd_d;
    logic [DISP_W-1:0]   best_d_q, best_d_d;
    logic [PIX_W-1:0]    dp_right_q, dp_right_d;
    logic                dp_valid_q, dp_valid_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic [SSD_W-1:0]    min_ssd_q, min_ssd_d;
    logic                collect_s;

    assign ready_out     = ready_q;
    assign dp_left_out   = left_q;
    assign dp_right_out  = dp_right_q;
    assign dp_valid_out  = dp_valid_q;
    assign disparity_out = disp_q;
    assign min_ssd_out   = min_ssd_q;
    assign err_out       = err_q;
    assign valid_out     = valid_q;

    // Next-state, result collection and output latching.
    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        right_d     = right_q;
        issue_cnt_d = issue_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        best_ssd_d  = best_ssd_q;
        best_d_d    = best_d_q;
        dp_right_d  = dp_right_q;
        dp_valid_d  = dp_valid_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        err_d       = err_q;
        disp_d      = disp_q;
        min_ssd_d   = min_ssd_q;

        // Results only count while a pixel is in flight; extras beyond NUM_DISP are dropped.
        collect_s = dp_valid_in && ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                    && (rcv_cnt_q != ALL_CNT);

        if (collect_s) begin
            rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
            // Strict less-than: on ties the earlier (lower) disparity wins.
            if ((rcv_cnt_q == {CNT_W{1'b0}}) || (dp_ssd_in < best_ssd_q)) begin
                best_ssd_d = dp_ssd_in;
                best_d_d   = rcv_cnt_q[DISP_W-1:0];
            end else begin
                best_ssd_d = best_ssd_q;
            end
        end else begin
            rcv_cnt_d = rcv_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    left_d = left_pixel_in;
                    for (int d = 0; d < NUM_DISP; d++) begin
                        right_d[d] = right_pixels_in[d*PIX_W +: PIX_W];
                    end
                    issue_cnt_d = {CNT_W{1'b0}};
                    rcv_cnt_d   = {CNT_W{1'b0}};
                    best_ssd_d  = {SSD_W{1'b1}};
                    best_d_d    = {DISP_W{1'b0}};
                    dp_right_d  = right_pixels_in[PIX_W-1:0];
                    dp_valid_d  = 1'b1;
                    ready_d     = 1'b0;
                    state_d     = S_ISSUE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (issue_cnt_q == LAST_IDX) begin
                    dp_valid_d = 1'b0;
                    idle_cnt_d = {IDLE_W{1'b0}};
                    state_d    = S_DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    dp_right_d  = right_q[issue_cnt_q + CNT_W'(1)];
                end
            end
            S_DRAIN: begin
                // Uses the post-update count so the last result goes straight to OUTPUT.
                if (rcv_cnt_d == ALL_CNT) begin
                    disp_d    = best_d_d;
                    min_ssd_d = best_ssd_d;
                    err_d     = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = S_OUTPUT;
                end else if (collect_s) begin
                    idle_cnt_d = {IDLE_W{1'b0}};
                end else if (idle_cnt_q == TO_LAST) begin
                    disp_d    = best_d_q;
                    min_ssd_d = best_ssd_q;
                    err_d     = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = S_OUTPUT;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            S_OUTPUT: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                dp_valid_d = 1'b0;
                valid_d    = 1'b0;
                ready_d    = 1'b1;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            left_q      <= {PIX_W{1'b0}};
            for (int i = 0; i < NUM_DISP; i++) begin
                right_q[i] <= {PIX_W{1'b0}};
            end
            issue_cnt_q <= {CNT_W{1'b0}};
            rcv_cnt_q   <= {CNT_W{1'b0}};
            idle_cnt_q  <= {IDLE_W{1'b0}};
            best_ssd_q  <= {SSD_W{1'b1}};
            best_d_q    <= {DISP_W{1'b0}};
            dp_right_q  <= {PIX_W{1'b0}};
            dp_valid_q  <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            disp_q      <= {DISP_W{1'b0}};
            min_ssd_q   <= {SSD_W{1'b0}};
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            right_q     <= right_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            best_ssd_q  <= best_ssd_d;
            best_d_q    <= best_d_d;
            dp_right_q  <= dp_right_d;
            dp_valid_q  <= dp_valid_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            disp_q      <= disp_d;
            min_ssd_q   <= min_ssd_d;
        end
    end

endmodule

// File: tb/tb_disparity_wta_scheduler.sv
// -----------------------------------------------------------------------------
// tb_disparity_wta_scheduler
//   Directed bench for disparity_wta_scheduler. A behavioural matcher returns
//   (left-right)^2 two cycles after each issue and can drop one chosen issue.
// -----------------------------------------------------------------------------
module tb_disparity_wta_scheduler;

    localparam int ND  = 9;
    localparam int PW  = 4;
    localparam int SW  = 9;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              valid_in;
    logic              ready_out;
    logic [PW-1:0]     left_pixel_in;
    logic [ND*PW-1:0]  right_pixels_in;
    logic [PW-1:0]     dp_left_out;
    logic [PW-1:0]     dp_right_out;
    logic              dp_valid_out;
    logic [SW-1:0]     dp_ssd_in;
    logic              dp_valid_in;
    logic [3:0]        disparity_out;
    logic [SW-1:0]     min_ssd_out;
    logic              err_out;
    logic              valid_out;
    logic              ready_in;

    int total = 0;
    int bad   = 0;
    int drop_idx = -1;
    int issue_no = 0;

    logic [LAT-1:0] vpipe;
    logic [SW-1:0]  spipe [LAT];

    disparity_wta_scheduler #(
        .NUM_DISP(ND), .PIX_W(PW), .SSD_W(SW), .MATCH_LAT(LAT), .TIMEOUT(32)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .left_pixel_in(left_pixel_in), .right_pixels_in(right_pixels_in),
        .dp_left_out(dp_left_out), .dp_right_out(dp_right_out),
        .dp_valid_out(dp_valid_out), .dp_ssd_in(dp_ssd_in), .dp_valid_in(dp_valid_in),
        .disparity_out(disparity_out), .min_ssd_out(min_ssd_out), .err_out(err_out),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] sqd(input logic [PW-1:0] a, input logic [PW-1:0] b);
        int df;
        df = int'(a) - int'(b);
        return SW'(df * df);
    endfunction

    // Matcher model: fixed-latency pipeline, optional drop of one issue index.
    always @(posedge clk) begin
        if (!rst_in) begin
            vpipe    <= '0;
            issue_no <= 0;
            for (int i = 0; i < LAT; i++) spipe[i] <= '0;
        end else begin
            vpipe[0] <= dp_valid_out && (issue_no != drop_idx);
            spipe[0] <= sqd(dp_left_out, dp_right_out);
            for (int i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                spipe[i] <= spipe[i-1];
            end
            issue_no <= dp_valid_out ? issue_no + 1 : 0;
        end
    end

    assign dp_valid_in = vpipe[LAT-1];
    assign dp_ssd_in   = spipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ND*PW-1:0] pack(input int v [ND]);
        logic [ND*PW-1:0] r;
        for (int d = 0; d < ND; d++) r[d*PW +: PW] = PW'(v[d]);
        return r;
    endfunction

    task automatic send(input logic [PW-1:0] l, input logic [ND*PW-1:0] r);
        left_pixel_in   = l;
        right_pixels_in = r;
        valid_in        = 1'b1;
        tick();
        valid_in        = 1'b0;
    endtask

    // Called in cycle 1 after accept; returns cycle index at which valid_out is seen.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!valid_out && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        tick();
        tick();
        total++; if (ready_out !== 1'b1)     begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_out); end
        total++; if (valid_out !== 1'b0)     begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
        total++; if (dp_valid_out !== 1'b0)  begin bad++; $display("FAIL rst_dpvalid got=%b exp=0", dp_valid_out); end
        total++; if (err_out !== 1'b0)       begin bad++; $display("FAIL rst_err got=%b exp=0", err_out); end
        total++; if (disparity_out !== 4'd0) begin bad++; $display("FAIL rst_disp got=%0d exp=0", disparity_out); end
        total++; if (min_ssd_out !== 9'd0)   begin bad++; $display("FAIL rst_ssd got=%0d exp=0", min_ssd_out); end
        rst_in = 1'b1;
        tick();
        total++; if (ready_out !== 1'b1)     begin bad++; $display("FAIL idle_ready got=%b exp=1", ready_out); end
    endtask

    task automatic test_equal_ssd();
        int v [ND] = '{12, 8, 12, 8, 12, 8, 12, 8, 12};
        int cyc;
        send(4'd10, pack(v));
        total++; if (dp_valid_out !== 1'b1)  begin bad++; $display("FAIL eq_issue got=%b exp=1", dp_valid_out); end
        total++; if (dp_right_out !== 4'd12) begin bad++; $display("FAIL eq_right0 got=%0d exp=12", dp_right_out); end
        total++; if (ready_out !== 1'b0)     begin bad++; $display("FAIL eq_busy got=%b exp=0", ready_out); end
        wait_valid(cyc);
        total++; if (cyc != 12)              begin bad++; $display("FAIL eq_latency got=%0d exp=12", cyc); end
        total++; if (disparity_out !== 4'd0) begin bad++; $display("FAIL eq_disp got=%0d exp=0", disparity_out); end
        total++; if (min_ssd_out !== 9'd4)   begin bad++; $display("FAIL eq_ssd got=%0d exp=4", min_ssd_out); end
        total++; if (err_out !== 1'b0)       begin bad++; $display("FAIL eq_err got=%b exp=0", err_out); end
        tick();
        total++; if (valid_out !== 1'b0)     begin bad++; $display("FAIL eq_xfer_valid got=%b exp=0", valid_out); end
        total++; if (ready_out !== 1'b1)     begin bad++; $display("FAIL eq_xfer_ready got=%b exp=1", ready_out); end
    endtask

    task automatic test_min_mid();
        int v [ND] = '{0, 1, 2, 3, 4, 7, 9, 11, 15};
        int cyc;
        send(4'd7, pack(v));
        wait_valid(cyc);
        total++; if (cyc != 12)              begin bad++; $display("FAIL mid_latency got=%0d exp=12", cyc); end
        total++; if (disparity_out !== 4'd5) begin bad++; $display("FAIL mid_disp got=%0d exp=5", disparity_out); end
        total++; if (min_ssd_out !== 9'd0)   begin bad++; $display("FAIL mid_ssd got=%0d exp=0", min_ssd_out); end
        tick();
    endtask

    task automatic test_last_wins();
        int v [ND] = '{15, 14, 13, 12, 11, 10, 9, 8, 7};
        int cyc;
        send(4'd3, pack(v));
        wait_valid(cyc);
        total++; if (disparity_out !== 4'd8) begin bad++; $display("FAIL last_disp got=%0d exp=8", disparity_out); end
        total++; if (min_ssd_out !== 9'd16)  begin bad++; $display("FAIL last_ssd got=%0d exp=16", min_ssd_out); end
        tick();
    endtask

    task automatic test_backpressure();
        int v [ND] = '{0, 1, 2, 3, 4, 7, 9, 11, 15};
        int w [ND] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        int cyc;
        ready_in = 1'b0;
        send(4'd7, pack(v));
        wait_valid(cyc);
        left_pixel_in   = 4'd1;
        right_pixels_in = pack(w);
        valid_in        = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++; if (valid_out !== 1'b1 || disparity_out !== 4'd5 || min_ssd_out !== 9'd0 || err_out !== 1'b0)
                begin bad++; $display("FAIL hold_out k=%0d got v=%b d=%0d s=%0d e=%b exp v=1 d=5 s=0 e=0", k, valid_out, disparity_out, min_ssd_out, err_out); end
            total++; if (ready_out !== 1'b0 || dp_valid_out !== 1'b0)
                begin bad++; $display("FAIL hold_busy k=%0d got rdy=%b dpv=%b exp 0 0", k, ready_out, dp_valid_out); end
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", valid_out); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", ready_out); end
        tick();
        total++; if (dp_valid_out !== 1'b0 || valid_out !== 1'b0)
            begin bad++; $display("FAIL bp_single_xfer got dpv=%b v=%b exp 0 0", dp_valid_out, valid_out); end
    endtask

    task automatic test_timeout();
        int v [ND] = '{0, 1, 2, 3, 4, 7, 9, 11, 15};
        int cyc;
        drop_idx = 4;
        send(4'd7, pack(v));
        wait_valid(cyc);
        total++; if (cyc != 44)              begin bad++; $display("FAIL to_latency got=%0d exp=44", cyc); end
        total++; if (err_out !== 1'b1)       begin bad++; $display("FAIL to_err got=%b exp=1", err_out); end
        total++; if (disparity_out !== 4'd4) begin bad++; $display("FAIL to_disp got=%0d exp=4", disparity_out); end
        total++; if (min_ssd_out !== 9'd0)   begin bad++; $display("FAIL to_ssd got=%0d exp=0", min_ssd_out); end
        drop_idx = -1;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        int v [ND] = '{15, 14, 13, 12, 11, 10, 9, 8, 7};
        send(4'd7, pack(v));
        repeat (9) tick();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        total++; if (ready_out !== 1'b1 || valid_out !== 1'b0 || dp_valid_out !== 1'b0 || err_out !== 1'b0
                     || disparity_out !== 4'd0 || min_ssd_out !== 9'd0)
            begin bad++; $display("FAIL mid_rst got rdy=%b v=%b dpv=%b e=%b d=%0d s=%0d exp 1 0 0 0 0 0",
                                  ready_out, valid_out, dp_valid_out, err_out, disparity_out, min_ssd_out); end
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_rst_quiet got=%b exp=0", valid_out); end
    endtask

    task automatic test_back_to_back();
        int a [ND] = '{0, 1, 2, 3, 4, 7, 9, 11, 15};
        int b [ND] = '{15, 14, 13, 12, 11, 10, 9, 8, 7};
        int c [ND] = '{12, 8, 12, 8, 12, 8, 12, 8, 12};
        logic [PW-1:0] lft [3] = '{4'd7, 4'd3, 4'd10};
        logic [3:0]    ed  [3] = '{4'd5, 4'd8, 4'd0};
        logic [SW-1:0] es  [3] = '{9'd0, 9'd16, 9'd4};
        logic [ND*PW-1:0] rs [3];
        int cyc;
        rs[0] = pack(a); rs[1] = pack(b); rs[2] = pack(c);
        for (int p = 0; p < 3; p++) begin
            total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL b2b_ready p=%0d got=%b exp=1", p, ready_out); end
            send(lft[p], rs[p]);
            wait_valid(cyc);
            total++; if (cyc != 12 || disparity_out !== ed[p] || min_ssd_out !== es[p])
                begin bad++; $display("FAIL b2b_result p=%0d got cyc=%0d d=%0d s=%0d exp cyc=12 d=%0d s=%0d",
                                      p, cyc, disparity_out, min_ssd_out, ed[p], es[p]); end
            tick();
        end
    endtask

    initial begin
        rst_in          = 1'b0;
        valid_in        = 1'b0;
        ready_in        = 1'b1;
        left_pixel_in   = '0;
        right_pixels_in = '0;
        test_reset();
        test_equal_ssd();
        test_min_mid();
        test_last_wins();
        test_backpressure();
        test_timeout();
        test_reset_mid_drain();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
